// File: rtl/ternary_weight_pingpong_buffer_pkg.sv
// ============================================================================
// Module   : ternary_weight_pingpong_buffer_pkg
// Brief    : Shared defaults, bank-state encoding and helpers for the
//            ternary weight ping-pong buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ternary_weight_pingpong_buffer_pkg;

  localparam int TN_DEF           = 4;
  localparam int KERNEL_SIZE_DEF  = 3;
  localparam int KERNEL_WIDTH_DEF = 2;
  localparam int DEPTH_DEF        = 32;

  // Life cycle of one bank: filled by the loader, then consumed by the datapath
  typedef enum logic [1:0] {
    WB_EMPTY   = 2'd0,
    WB_LOADING = 2'd1,
    WB_READY   = 2'd2
  } wb_state_e;

  // A zero or oversized request means "fill the whole bank"
  function automatic int clamp_load_count(input int req, input int depth);
    return ((req == 0) || (req > depth)) ? depth : req;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ternary_weight_pingpong_buffer_wbuf_bank_ram.sv
// ============================================================================
// Module   : wbuf_bank_ram
// Brief    : One weight bank: DEPTH x WORD_W storage with a single write port
//            and a single registered read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wbuf_bank_ram #(
  parameter int DEPTH  = 32,
  parameter int WORD_W = 72,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Write port: one word per accepted loader beat
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: output register only updates on an actual read
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ternary_weight_pingpong_buffer.sv
// ============================================================================
// Module   : ternary_weight_pingpong_buffer
// Brief    : Two-bank ternary weight buffer. The loader fills the write bank
//            while the datapath reads the other bank with 1-cycle latency.
//            Optional macro WBUF_STALL_CNT_EN adds a saturating 32-bit
//            stall_cycles counter (read requested while no bank is ready).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ternary_weight_pingpong_buffer
  import ternary_weight_pingpong_buffer_pkg::*;
#(
  parameter int TN           = TN_DEF,
  parameter int KERNEL_SIZE  = KERNEL_SIZE_DEF,
  parameter int KERNEL_WIDTH = KERNEL_WIDTH_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int WORD_W       = TN * KERNEL_SIZE * KERNEL_SIZE * KERNEL_WIDTH,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [AW:0]       load_count,
  output logic              load_start_ready,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  input  logic [15:0]       weight_addr,
  input  logic              weight_read_en,
  output logic [WORD_W-1:0] weight_wire,
  output logic              weight_valid,
  output logic              weights_ready,
`ifdef WBUF_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  input  logic              tile_release,
  output logic              oor_err
);

  // Bank bookkeeping
  wb_state_e         state_q [2];
  logic [AW:0]       cnt_q   [2];
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic [AW-1:0]     wptr_q;
  logic              load_done_q;

  // Read pipeline stage
  logic              rd_hit_q;
  logic              rd_oor_q;
  logic              rd_miss_q;
  logic              rd_sel_q;
  logic              oor_q;
  logic [WORD_W-1:0] wire_hold_q;

  logic [WORD_W-1:0] ram_rdata [2];

  logic              beat;
  logic              last_beat;
  logic [AW-1:0]     rd_addr;
  logic              rd_req;
  logic              rd_in_range;
  logic              rd_mem;
  logic [AW:0]       clamped_cnt;

  // Handshake status comes straight from registered bank state
  assign load_start_ready = (state_q[wr_bank_q] == WB_EMPTY);
  assign load_ready       = (state_q[wr_bank_q] == WB_LOADING);
  assign weights_ready    = (state_q[rd_bank_q] == WB_READY);

  assign beat        = load_valid && load_ready;
  assign last_beat   = beat && ({1'b0, wptr_q} == (cnt_q[wr_bank_q] - 1'b1));
  assign clamped_cnt = (AW+1)'(clamp_load_count(int'(load_count), DEPTH));

  // Only the low address bits select a word; range is checked against the
  // bank's loaded count so partially filled banks flag stale reads
  assign rd_addr     = weight_addr[AW-1:0];
  assign rd_req      = weight_read_en && weights_ready;
  assign rd_in_range = ({1'b0, rd_addr} < cnt_q[rd_bank_q]);
  assign rd_mem      = rd_req && rd_in_range;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    wbuf_bank_ram #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W),
      .AW     (AW)
    ) u_ram (
      .clk     (clk),
      .we_i    (beat && (wr_bank_q == 1'(b))),
      .waddr_i (wptr_q),
      .wdata_i (load_data),
      .re_i    (rd_mem && (rd_bank_q == 1'(b))),
      .raddr_i (rd_addr),
      .rdata_o (ram_rdata[b])
    );
  end

  // Bank state machines and ping-pong pointers. Load and release act on
  // different banks (LOADING vs READY), so both may fire in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0]  <= WB_EMPTY;
      state_q[1]  <= WB_EMPTY;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wptr_q      <= '0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= last_beat;
      if (load_start && load_start_ready) begin
        state_q[wr_bank_q] <= WB_LOADING;
        cnt_q[wr_bank_q]   <= clamped_cnt;
        wptr_q             <= '0;
      end else if (beat) begin
        wptr_q <= wptr_q + 1'b1;
        if (last_beat) begin
          state_q[wr_bank_q] <= WB_READY;
          wr_bank_q          <= ~wr_bank_q;
        end
      end
      if (tile_release && weights_ready) begin
        state_q[rd_bank_q] <= WB_EMPTY;
        rd_bank_q          <= ~rd_bank_q;
      end
    end
  end

  // Capture read outcome; the bank select is latched so a read issued with
  // tile_release still returns the old bank's word
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_hit_q    <= 1'b0;
      rd_oor_q    <= 1'b0;
      rd_miss_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
      oor_q       <= 1'b0;
      wire_hold_q <= '0;
    end else begin
      rd_hit_q    <= rd_mem;
      rd_oor_q    <= rd_req && !rd_in_range;
      rd_miss_q   <= weight_read_en && !weights_ready;
      rd_sel_q    <= rd_bank_q;
      wire_hold_q <= weight_wire;
      if (rd_req && !rd_in_range) begin
        oor_q <= 1'b1;
      end
    end
  end

  // Hit returns RAM data, failed/out-of-range reads return zero, idle holds
  always_comb begin
    weight_wire = wire_hold_q;
    if (rd_hit_q) begin
      weight_wire = ram_rdata[rd_sel_q];
    end else if (rd_oor_q || rd_miss_q) begin
      weight_wire = '0;
    end
  end

  assign weight_valid = rd_hit_q || rd_oor_q;
  assign load_done    = load_done_q;
  assign oor_err      = oor_q;

`ifdef WBUF_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count cycles the datapath asks for weights that are not there yet
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (weight_read_en && !weights_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ternary_weight_pingpong_buffer.sv
// ============================================================================
// Module   : tb_ternary_weight_pingpong_buffer
// Brief    : Directed self-checking bench for the ternary weight buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ternary_weight_pingpong_buffer;

  localparam int WW = 72;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW:0]   load_count;
  logic          load_start_ready;
  logic          load_valid;
  logic [WW-1:0] load_data;
  logic          load_ready;
  logic          load_done;
  logic [15:0]   weight_addr;
  logic          weight_read_en;
  logic [WW-1:0] weight_wire;
  logic          weight_valid;
  logic          weights_ready;
  logic          tile_release;
  logic          oor_err;
`ifdef WBUF_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  int errors = 0;
  int checks = 0;
  int done_cnt;
  logic [WW-1:0] pat_a5;

  always #5 clk = ~clk;

  ternary_weight_pingpong_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .load_start       (load_start),
    .load_count       (load_count),
    .load_start_ready (load_start_ready),
    .load_valid       (load_valid),
    .load_data        (load_data),
    .load_ready       (load_ready),
    .load_done        (load_done),
    .weight_addr      (weight_addr),
    .weight_read_en   (weight_read_en),
    .weight_wire      (weight_wire),
    .weight_valid     (weight_valid),
    .weights_ready    (weights_ready),
`ifdef WBUF_STALL_CNT_EN
    .stall_cycles     (stall_cycles),
`endif
    .tile_release     (tile_release),
    .oor_err          (oor_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    pat_a5         = {9{8'hA5}};
    rst            = 1'b1;
    load_start     = 1'b0;
    load_count     = '0;
    load_valid     = 1'b0;
    load_data      = '0;
    weight_addr    = '0;
    weight_read_en = 1'b0;
    tile_release   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_weights_ready", 72'(weights_ready), 72'd0);
    chk("rst_load_start_ready", 72'(load_start_ready), 72'd1);
    chk("rst_load_ready", 72'(load_ready), 72'd0);
    chk("rst_weight_valid", 72'(weight_valid), 72'd0);
    chk("rst_weight_wire", weight_wire, 72'd0);
    chk("rst_load_done", 72'(load_done), 72'd0);
    chk("rst_oor_err", 72'(oor_err), 72'd0);

    // Reads with nothing loaded never produce valid data
    weight_read_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      weight_addr = 16'(i);
      tick();
      chk("notready_valid", 72'(weight_valid), 72'd0);
    end
    chk("notready_wire", weight_wire, 72'd0);
`ifdef WBUF_STALL_CNT_EN
    chk("stall_cycles", 72'(stall_cycles), 72'd10);
`endif
    weight_read_en = 1'b0;

    // Basic fill of bank0 with 32 words, word i = i
    load_start = 1'b1;
    load_count = 6'd32;
    tick();
    load_start = 1'b0;
    chk("fill0_load_ready", 72'(load_ready), 72'd1);
    chk("fill0_start_ready", 72'(load_start_ready), 72'd0);
    done_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      load_valid = 1'b1;
      load_data  = 72'(i);
      tick();
      if (load_done) done_cnt++;
    end
    load_valid = 1'b0;
    chk("fill0_weights_ready", 72'(weights_ready), 72'd1);
    chk("fill0_start_ready_b1", 72'(load_start_ready), 72'd1);
    tick();
    if (load_done) done_cnt++;
    chk("fill0_done_pulses", 72'(done_cnt), 72'd1);

    // Back-to-back reads of the whole bank
    weight_read_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      weight_addr = 16'(i);
      tick();
      chk("rd0_valid", 72'(weight_valid), 72'd1);
      chk("rd0_data", weight_wire, 72'(i));
    end
    weight_read_en = 1'b0;
    tick();
    chk("idle_valid", 72'(weight_valid), 72'd0);
    chk("idle_hold", weight_wire, 72'd31);
    chk("rd0_oor", 72'(oor_err), 72'd0);

    // Fill bank1 with the A5 pattern while reading bank0
    load_start = 1'b1;
    load_count = 6'd4;
    tick();
    load_start = 1'b0;
    chk("fill1_load_ready", 72'(load_ready), 72'd1);
    weight_read_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_valid  = 1'b1;
      load_data   = pat_a5;
      weight_addr = 16'(i);
      tick();
      chk("overlap_rd_data", weight_wire, 72'(i));
    end
    load_valid     = 1'b0;
    weight_read_en = 1'b0;
    chk("fill1_done", 72'(load_done), 72'd1);
    chk("full_start_ready", 72'(load_start_ready), 72'd0);
    chk("full_load_ready", 72'(load_ready), 72'd0);

    // Third load_start with both banks full is ignored
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("third_start_load_ready", 72'(load_ready), 72'd0);
    chk("third_start_ready", 72'(load_start_ready), 72'd0);

    // Release bank0 with a simultaneous read: old bank answers
    tile_release   = 1'b1;
    weight_read_en = 1'b1;
    weight_addr    = 16'd5;
    tick();
    tile_release = 1'b0;
    chk("rel_rd_old_bank", weight_wire, 72'd5);
    chk("rel_weights_ready", 72'(weights_ready), 72'd1);
    chk("rel_start_ready", 72'(load_start_ready), 72'd1);
    weight_addr = 16'd2;
    tick();
    chk("rd1_valid", 72'(weight_valid), 72'd1);
    chk("rd1_data", weight_wire, pat_a5);
    weight_read_en = 1'b0;

    // Release bank1, then load 5 words into bank0 and read out of range
    tile_release = 1'b1;
    tick();
    tile_release = 1'b0;
    chk("rel1_weights_ready", 72'(weights_ready), 72'd0);
    load_start = 1'b1;
    load_count = 6'd5;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = 72'(100 + i);
      tick();
    end
    load_valid = 1'b0;
    chk("fill5_done", 72'(load_done), 72'd1);
    weight_read_en = 1'b1;
    weight_addr    = 16'd4;
    tick();
    chk("rd5_last", weight_wire, 72'd104);
    chk("rd5_oor_clear", 72'(oor_err), 72'd0);
    weight_addr = 16'd7;
    tick();
    chk("oor_wire", weight_wire, 72'd0);
    chk("oor_valid", 72'(weight_valid), 72'd1);
    chk("oor_err_set", 72'(oor_err), 72'd1);
    weight_addr = 16'd0;
    tick();
    chk("oor_after_data", weight_wire, 72'd100);
    chk("oor_sticky", 72'(oor_err), 72'd1);
    weight_read_en = 1'b0;

    // Reset in the middle of an 8-word load into bank1
    load_start = 1'b1;
    load_count = 6'd8;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 72'(50 + i);
      tick();
    end
    load_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_weights_ready", 72'(weights_ready), 72'd0);
    chk("mid_rst_start_ready", 72'(load_start_ready), 72'd1);
    chk("mid_rst_load_ready", 72'(load_ready), 72'd0);
    chk("mid_rst_oor", 72'(oor_err), 72'd0);

    // Fresh load lands in bank0 and reads back normally
    load_start = 1'b1;
    load_count = 6'd8;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1;
      load_data  = 72'(200 + i);
      tick();
    end
    load_valid = 1'b0;
    chk("fresh_done", 72'(load_done), 72'd1);
    chk("fresh_weights_ready", 72'(weights_ready), 72'd1);
    weight_read_en = 1'b1;
    weight_addr    = 16'd7;
    tick();
    chk("fresh_rd7", weight_wire, 72'd207);
    weight_addr = 16'd0;
    tick();
    chk("fresh_rd0", weight_wire, 72'd200);
    weight_read_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
